// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, line-level constants and frame sizing.
// Imported by both the transmit serializer and the receive-side deserializer.
package uart_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic LINE_IDLE = 1'b1;

    function automatic int frame_w(input int data_width, input int parity_en, input int stop_bits);
        return 1 + data_width + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/uart_parity.sv
// Combinational parity generator shared by the UART transmitter and receiver.
// Produces even parity (XOR of data), or its inverse when PARITY_ODD is set.
module uart_parity #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  parity
);

    assign parity = (^data) ^ (PARITY_ODD != 0);

endmodule

// File: rtl/piso_tx.sv
// UART transmit serializer: latches one word per valid/ready handshake and
// shifts start, data (LSB first), optional parity and stop bits, one per baud_clk.
//
// state | meaning
// IDLE  | line held high, tx_ready asserted, waiting for a handshake
// SHIFT | frame on the line, one bit per cycle until the last stop bit completes
module piso_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  baud_clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  data_tx,
    output logic                  active_flag,
    output logic                  done_flag
);

    localparam int FRAME_W = frame_w(DATA_WIDTH, PARITY_EN, STOP_BITS);
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);

    state_t             state;
    state_t             state_nxt;
    logic [FRAME_W-1:0] shift_reg;
    logic [FRAME_W-1:0] shift_nxt;
    logic [FRAME_W-1:0] frame_load;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               data_nxt;
    logic               active_nxt;
    logic               done_nxt;
    logic               parity;

    uart_parity #(
        .DATA_WIDTH (DATA_WIDTH),
        .PARITY_ODD (PARITY_ODD)
    ) u_parity (
        .data   (tx_data),
        .parity (parity)
    );

    assign tx_ready = (state == IDLE) && !reset;

    always_comb begin
        frame_load = {FRAME_W{STOP_BIT}};
        frame_load[0] = START_BIT;
        frame_load[DATA_WIDTH:1] = tx_data;
        if (PARITY_EN != 0) begin
            frame_load[DATA_WIDTH+1] = parity;
        end
    end

    // The start bit goes straight to data_tx; the register holds the remaining bits.
    always_comb begin
        state_nxt  = state;
        shift_nxt  = shift_reg;
        cnt_nxt    = bit_cnt;
        data_nxt   = data_tx;
        active_nxt = active_flag;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    shift_nxt  = {STOP_BIT, frame_load[FRAME_W-1:1]};
                    cnt_nxt    = '0;
                    data_nxt   = frame_load[0];
                    active_nxt = 1'b1;
                    state_nxt  = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt == LAST_CNT) begin
                    state_nxt  = IDLE;
                    data_nxt   = LINE_IDLE;
                    active_nxt = 1'b0;
                    done_nxt   = 1'b1;
                end else begin
                    data_nxt  = shift_reg[0];
                    shift_nxt = {STOP_BIT, shift_reg[FRAME_W-1:1]};
                    cnt_nxt   = bit_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge baud_clk) begin
        if (reset) begin
            state       <= IDLE;
            shift_reg   <= '1;
            bit_cnt     <= '0;
            data_tx     <= LINE_IDLE;
            active_flag <= 1'b0;
            done_flag   <= 1'b0;
        end else begin
            state       <= state_nxt;
            shift_reg   <= shift_nxt;
            bit_cnt     <= cnt_nxt;
            data_tx     <= data_nxt;
            active_flag <= active_nxt;
            done_flag   <= done_nxt;
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: three instances (default, odd parity, no parity with two stops)
// checked bit by bit against a frame scoreboard filled at each handshake.
module tb_piso_tx;

    logic       baud_clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic [2:0] valid;
    logic [2:0] ready;
    logic [2:0] dtx;
    logic [2:0] act;
    logic [2:0] done;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;
    logic exp_q[$];
    int run_len[3]  = '{0, 0, 0};
    int done_cnt[3] = '{0, 0, 0};

    localparam int FRAME_LEN = 11;

    always #5 baud_clk = ~baud_clk;

    piso_tx dut0 (
        .baud_clk(baud_clk), .reset(reset), .tx_data(tx_data), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .data_tx(dtx[0]), .active_flag(act[0]), .done_flag(done[0])
    );

    piso_tx #(.PARITY_ODD(1)) dut1 (
        .baud_clk(baud_clk), .reset(reset), .tx_data(tx_data), .tx_valid(valid[1]),
        .tx_ready(ready[1]), .data_tx(dtx[1]), .active_flag(act[1]), .done_flag(done[1])
    );

    piso_tx #(.PARITY_EN(0), .STOP_BITS(2)) dut2 (
        .baud_clk(baud_clk), .reset(reset), .tx_data(tx_data), .tx_valid(valid[2]),
        .tx_ready(ready[2]), .data_tx(dtx[2]), .active_flag(act[2]), .done_flag(done[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] d, input int pe, input int po, input int sb);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (pe != 0) exp_q.push_back((^d) ^ (po != 0));
        for (int s = 0; s < sb; s++) exp_q.push_back(1'b1);
    endtask

    // Called at a falling edge; returns 1 ns after the handshake edge.
    task automatic send(input int sel, input logic [7:0] d, input int pe, input int po, input int sb);
        int n;
        n = 0;
        tx_data    = d;
        valid[sel] = 1'b1;
        while (!ready[sel] && n < 50) begin
            @(negedge baud_clk);
            n++;
        end
        chk("handshake_ready", ready[sel], 1'b1);
        @(posedge baud_clk);
        #1;
        push_frame(d, pe, po, sb);
        valid[sel] = 1'b0;
    endtask

    task automatic wait_done(input int sel);
        int n;
        n = 0;
        do begin
            @(negedge baud_clk);
            n++;
        end while (!done[sel] && n < 60);
        chk("done_seen", done[sel], 1'b1);
        @(negedge baud_clk);
        chk("done_one_cycle", done[sel], 1'b0);
    endtask

    always @(negedge baud_clk) begin
        if (mon_en && !reset) begin
            for (int i = 0; i < 3; i++) begin
                if (act[i]) begin
                    chk("ready_busy", ready[i], 1'b0);
                    chk("done_in_frame", done[i], 1'b0);
                    if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
                    else chk($sformatf("bit%0d_dut%0d", run_len[i], i), dtx[i], exp_q.pop_front());
                    run_len[i]++;
                end else begin
                    chk("line_idle", dtx[i], 1'b1);
                    if (done[i]) begin
                        chk("frame_len", run_len[i], FRAME_LEN);
                        chk("sb_empty", exp_q.size(), 0);
                        chk("ready_in_done", ready[i], 1'b1);
                        run_len[i] = 0;
                        done_cnt[i]++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset   = 1'b1;
        valid   = 3'b000;
        tx_data = 8'h00;
        repeat (3) @(negedge baud_clk);
        chk("rst_data_tx", dtx[0], 1'b1);
        chk("rst_active", act[0], 1'b0);
        chk("rst_done", done[0], 1'b0);
        chk("rst_ready", ready[0], 1'b0);
        @(posedge baud_clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;
        @(negedge baud_clk);
        chk("ready_after_rst", ready[0], 1'b1);

        repeat (20) begin
            @(negedge baud_clk);
            chk("idle_active", act[0], 1'b0);
            chk("idle_done", done[0], 1'b0);
            chk("idle_ready", ready[0], 1'b1);
            chk("idle_line", dtx[0], 1'b1);
        end

        send(0, 8'hA5, 1, 0, 1);
        @(negedge baud_clk);
        chk("start_latency", act[0], 1'b1);
        chk("start_bit", dtx[0], 1'b0);
        wait_done(0);

        send(1, 8'h07, 1, 1, 1);
        wait_done(1);
        send(0, 8'h07, 1, 0, 1);
        wait_done(0);
        send(2, 8'h81, 0, 0, 2);
        wait_done(2);

        send(0, 8'h00, 1, 0, 1);
        tx_data = 8'hFF;
        wait_done(0);

        tx_data  = 8'h55;
        valid[0] = 1'b1;
        n = 0;
        while (!ready[0] && n < 50) begin
            @(negedge baud_clk);
            n++;
        end
        @(posedge baud_clk);
        #1;
        push_frame(8'h55, 1, 0, 1);
        tx_data = 8'h0F;
        n = 0;
        @(negedge baud_clk);
        while (!ready[0] && n < 50) begin
            n++;
            @(negedge baud_clk);
        end
        chk("b2b_wait", n, FRAME_LEN);
        chk("b2b_done_cycle", done[0], 1'b1);
        chk("b2b_idle_gap", dtx[0], 1'b1);
        @(posedge baud_clk);
        #1;
        push_frame(8'h0F, 1, 0, 1);
        valid[0] = 1'b0;
        @(negedge baud_clk);
        chk("b2b_start_active", act[0], 1'b1);
        chk("b2b_start_bit", dtx[0], 1'b0);
        wait_done(0);

        send(0, 8'hC3, 1, 0, 1);
        repeat (5) @(negedge baud_clk);
        reset = 1'b1;
        repeat (2) begin
            @(negedge baud_clk);
            chk("abort_line", dtx[0], 1'b1);
            chk("abort_active", act[0], 1'b0);
            chk("abort_ready", ready[0], 1'b0);
            chk("abort_done", done[0], 1'b0);
        end
        exp_q.delete();
        run_len[0] = 0;
        @(posedge baud_clk);
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge baud_clk);
            chk("abort_no_done", done[0], 1'b0);
        end
        send(0, 8'h3C, 1, 0, 1);
        wait_done(0);

        repeat (3) @(negedge baud_clk);
        chk("done_count0", done_cnt[0], 6);
        chk("done_count1", done_cnt[1], 1);
        chk("done_count2", done_cnt[2], 1);
        chk("sb_final_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
UART transmit serializer. Accepts one parallel byte per valid/ready handshake and builds a frame: start bit, data bits LSB first, optional parity, stop bit(s). Shifts the frame onto the serial line at one bit per baud_clk cycle. Sits between the host-side byte source and the serial pin. Its wire format is exactly the one our receive-side deserializer captures.

Parameters:
DATA_WIDTH, 8, number of payload bits per frame.
PARITY_EN, 1, 1 inserts a parity bit after the data bits; 0 omits it.
PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity. Ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
baud_clk  input  1  bit-rate clock; one serial bit per cycle.
reset  input  1  synchronous, active-high reset.
tx_data  input  DATA_WIDTH  payload byte; sampled only on the handshake edge.
tx_valid  input  1  tx_data holds a byte to send.
tx_ready  output  1  block can accept a byte this cycle.
data_tx  output  1  serial line, registered; idle level is 1.
active_flag  output  1  high while a frame is on the line (start bit through last stop bit).
done_flag  output  1  one-cycle pulse after the last stop bit completes.

Behaviour:
- FRAME_W = 1 + DATA_WIDTH + PARITY_EN + STOP_BITS. The default frame is 11 bits.
- Wire order: bit0 = start (0), bits 1..DATA_WIDTH = tx_data[0]..tx_data[DATA_WIDTH-1], then parity (if enabled), then stop bit(s) (1).
- Parity = XOR of tx_data for even parity, inverted for odd parity. It is computed from the value latched at the handshake.
- State machine has two states, IDLE and SHIFT.
- tx_ready = (state==IDLE) && !reset. It is 0 throughout SHIFT.
- Handshake: a transfer happens on a baud_clk edge where tx_valid && tx_ready. On that edge:
  - the full frame loads into the FRAME_W shift register;
  - bit_cnt <= 0;
  - data_tx <= 0 (start bit);
  - active_flag <= 1;
  - state <= SHIFT.
- tx_valid in IDLE without tx_ready never occurs. tx_data changes after the handshake have no effect on the frame in flight.
- SHIFT: each edge advances the frame by one bit (data_tx <= next frame bit) and increments bit_cnt. Every bit is held for exactly one cycle.
- End of frame: on the edge where bit_cnt == FRAME_W-1 (the last stop bit has been driven for one full cycle):
  - state <= IDLE;
  - data_tx <= 1;
  - active_flag <= 0;
  - done_flag <= 1 for exactly one cycle.
- Latency: the start bit appears on data_tx in the cycle immediately after the handshake edge. Each frame occupies exactly FRAME_W cycles of active_flag=1.
- Back-to-back: tx_ready is high in the done_flag cycle. A handshake in that cycle starts the next start bit on the following edge. This guarantees a minimum of one idle-high cycle between frames; this gap is required.
- done_flag is 0 in every cycle except the one after a completed frame.
- Reset values (synchronous, applied on any reset edge, including mid-frame): state=IDLE, data_tx=1, active_flag=0, done_flag=0, bit_cnt=0, shift register all 1s.
- A frame aborted by reset produces no done_flag. The line returns high on the reset edge.
- bit_cnt width is clog2(FRAME_W). It never wraps past FRAME_W-1.
- No output is combinational from tx_data or tx_valid. tx_ready depends only on state and reset.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum {IDLE, SHIFT};
  - constants START_BIT=0, STOP_BIT=1, LINE_IDLE=1;
  - the function frame_w(DATA_WIDTH, PARITY_EN, STOP_BITS).
- The receiver and transmitter both import uart_pkg.
- One sub-module: uart_parity, a combinational parity generator with parameters DATA_WIDTH and PARITY_ODD. It is shared with the receive-side parity checker.

Test Plan:
- Defaults, tx_data=0xA5, tx_valid pulsed in IDLE -> data_tx over the next 11 cycles is 0,1,0,1,0,0,1,0,1,0,1. active_flag=1 for exactly those 11 cycles. done_flag pulses once in cycle 12. tx_ready=0 in cycles 1–11.
- PARITY_ODD=1, tx_data=0x07 -> parity bit (cycle 10) = 0. The same byte with even parity gives 1. With PARITY_EN=0 and STOP_BITS=2 -> frame is 11 cycles with the last two bits =1.
- tx_valid held high with 0x55 then 0x0F -> second start bit begins exactly one idle-high cycle after the first frame's last stop bit. Each frame is bit-exact.
- tx_data changed to 0xFF one cycle after handshake of 0x00 -> all 8 data bits transmitted are 0.
- reset asserted at cycle 5 of a frame -> on the next edge data_tx=1, active_flag=0, tx_ready=0 while reset is held. No done_flag. After release, a new 0x3C frame transmits correctly.
- tx_valid=0 for 20 cycles after reset -> data_tx stays 1, active_flag=0, done_flag=0, tx_ready=1.
